// File: rtl/inc_dec_counter.sv
// rtl/inc_dec_counter.sv - bounded up/down counter with edge-detected inc/dec, sticky ovf/unf
// Optional INC_DEC_COUNTER_SATURATE_EN: hold at the bounds instead of wrapping.
module inc_dec_counter #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             chg,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic             inc_q, dec_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             chg_q, chg_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             inc_evt, dec_evt;

    assign inc_evt = inc & ~inc_q;
    assign dec_evt = dec & ~dec_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            count_d = MIN_V;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (inc_evt && !dec_evt) begin
            if (count_q == MAX_V) begin
                ovf_d = 1'b1;
`ifdef INC_DEC_COUNTER_SATURATE_EN
                count_d = MAX_V;
`else
                count_d = MIN_V;
`endif
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (dec_evt && !inc_evt) begin
            if (count_q == MIN_V) begin
                unf_d = 1'b1;
`ifdef INC_DEC_COUNTER_SATURATE_EN
                count_d = MIN_V;
`else
                count_d = MAX_V;
`endif
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
        // A clear never reports a change, even when it moves the count.
        chg_d = !clr && (count_d != count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            count_q <= MIN_V;
            chg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            inc_q   <= inc;
            dec_q   <= dec;
            count_q <= count_d;
            chg_q   <= chg_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count  = count_q;
    assign chg    = chg_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = (count_q == MAX_V);
    assign at_min = (count_q == MIN_V);

endmodule
